iccm_banked_sram_ctrl: RTL and testbench
========================================

Name: iccm_banked_sram_ctrl

Overview:
- Parametrised N-bank instruction closely-coupled memory (ICCM) controller built from sram_sp_16384x32_m32_be_wrap macros.
- Serves the core fetch port with a req/gnt/rvalid handshake.
- Accepts byte-enabled program writes from the loader/debug path.
- Arbitrates between fetch and program with a starvation guard, and generates read-data steering and hold internally.

Parameters:
- NUM_BANKS, 2, number of 16384x32 banks; power of two, 1..8.
- MAX_PROG_BURST, 8, consecutive program grants allowed while fetch is pending; 0 gives program absolute priority.
- BSEL_W, $clog2(NUM_BANKS) (min 1), derived bank-select width; not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch grant, same cycle as request
- instr_rvalid_o  out  1  fetch data valid
- instr_rdata_o  out  32  fetch data
- prog_req_i  in  1  program write request
- prog_addr_i  in  32  program byte address
- prog_wdata_i  in  32  program write data
- prog_be_i  in  4  program byte enables, active-high
- prog_gnt_o  out  1  program grant; write is performed in the grant cycle

Behaviour:
- Decode:
  - Word index = addr[15:2].
  - Bank = addr[16 +: BSEL_W] (bank 0 when NUM_BANKS==1).
  - addr[31:16+BSEL_W] and addr[1:0] are ignored, so the space aliases.
- Arbitration (combinational, per cycle):
  - Program only: prog_gnt_o=1.
  - Fetch only: instr_gnt_o=1.
  - Both: program wins, unless burst counter == MAX_PROG_BURST and MAX_PROG_BURST != 0; then fetch wins and the counter clears.
  - Grants are never asserted without the matching request. Never both grants in one cycle.
- Burst counter (width $clog2(MAX_PROG_BURST+1)):
  - Increments on each program grant issued while instr_req_i=1.
  - Clears on any fetch grant, or any cycle with instr_req_i=0.
  - Saturates at MAX_PROG_BURST.
- Macro drive:
  - Only the addressed bank has CEN=0; all others have CEN=1.
  - GWEN=0 only on a program grant.
  - BEN=~prog_be_i on a program grant, 4'b1111 on a fetch.
  - D=prog_wdata_i.
  - prog_be_i==0 with a grant consumes the slot with no memory change.
- Fetch latency:
  - instr_rvalid_o=1 exactly one cycle after each fetch grant; back-to-back grants give back-to-back rvalid.
  - Bank index is registered at grant and drives the read mux in the rvalid cycle.
- Data hold:
  - instr_rdata_o = selected bank Q when rvalid=1, else hold register.
  - Hold register captures the output on every rvalid.
  - Output stays stable across idle cycles and intervening program writes.
- Reset values: instr_rvalid_o=0, instr_rdata_o=32'h0 (hold register), burst counter=0, bank register=0.
- Reset asserted mid-operation: the pending rvalid is dropped. A write granted in the same cycle as the reset edge is not guaranteed.

Optional Feature:
- Macro: ICCM_RDATA_REG_EN.
- Defined:
  - Adds an output register stage after the bank mux.
  - instr_rvalid_o is asserted two cycles after grant.
  - instr_rdata_o comes directly from the flop and changes only when rvalid=1.
  - Throughput is unchanged at one fetch per cycle.
  - Reset values unchanged.
- Undefined: one-cycle latency as above.

Test Plan:
- Write 32'hDEADBEEF to 0x0001_0004 (be=4'hF), then fetch 0x0001_0004 -> instr_rdata_o=32'hDEADBEEF with rvalid one cycle after gnt. Fetch 0x0000_0004 -> old bank-0 contents, unaffected.
- Write 32'h11223344 to 0x0, then write 32'hAABBCCDD with be=4'b0101 to 0x0, then fetch 0x0 -> 32'h11BB33DD.
- Fetch requests held continuously while program requests are held continuously, MAX_PROG_BURST=8 -> 8 prog grants, 1 fetch grant, repeating. With MAX_PROG_BURST=0 -> fetch never granted.
- Back-to-back fetches alternating banks 0x0/0x10000/0x0 -> three consecutive rvalid cycles carrying the correct per-bank data. Then idle plus a program write -> instr_rdata_o holds the last value.
- NUM_BANKS=4: fetch 0x0003_0008 -> bank 3, word 2. Fetch 0x0007_0008 -> same word (alias).
- Assert rst_n low for one cycle immediately after a fetch grant -> no rvalid, instr_rdata_o=0. The next fetch completes normally. With ICCM_RDATA_REG_EN, rvalid arrives 2 cycles after grant.

Source files
------------

// File: rtl/iccm_banked_sram_ctrl.sv
// iccm_banked_sram_ctrl: N-bank ICCM controller with fetch/program arbitration and read-data hold.
// Define ICCM_RDATA_REG_EN to add an output register stage (two-cycle fetch latency).
module sram_sp_16384x32_m32_be_wrap (
  input  logic        clk,
  input  logic        cen,
  input  logic        gwen,
  input  logic [3:0]  ben,
  input  logic [13:0] a,
  input  logic [31:0] d,
  output logic [31:0] q
);
  logic [31:0] mem [16384];
  always_ff @(posedge clk)
    if (!cen) begin
      if (!gwen) begin
        for (int j = 0; j < 4; j++)
          if (!ben[j]) mem[a][j*8 +: 8] <= d[j*8 +: 8];
      end else begin
        q <= mem[a];
      end
    end
endmodule

module iccm_banked_sram_ctrl #(
  parameter int NUM_BANKS      = 2,
  parameter int MAX_PROG_BURST = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        prog_req_i,
  input  logic [31:0] prog_addr_i,
  input  logic [31:0] prog_wdata_i,
  input  logic [3:0]  prog_be_i,
  output logic        prog_gnt_o
);
  localparam int BSEL_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam int CW = MAX_PROG_BURST > 0 ? $clog2(MAX_PROG_BURST + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_PROG_BURST);
  logic [CW-1:0]     burst;
  logic              starve, any_gnt, rvalid_q, unused_addr;
  logic [31:0]       addr, rd_mux;
  logic [BSEL_W-1:0] bank, bank_q;
  logic [31:0]       q [NUM_BANKS];
  // fetch overrides program only once the burst budget is exhausted
  assign starve      = MAX_PROG_BURST != 0 && burst == CMAX;
  assign instr_gnt_o = instr_req_i & (~prog_req_i | starve);
  assign prog_gnt_o  = prog_req_i & ~instr_gnt_o;
  assign any_gnt     = instr_gnt_o | prog_gnt_o;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) burst <= '0;
    else if (!instr_req_i || instr_gnt_o) burst <= '0;
    else if (prog_gnt_o && burst != CMAX) burst <= burst + 1'b1;
  assign addr        = prog_gnt_o ? prog_addr_i : instr_addr_i;
  assign bank        = NUM_BANKS == 1 ? '0 : addr[16 +: BSEL_W];
  assign unused_addr = ^{addr[31:16+BSEL_W], addr[1:0]};
  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    sram_sp_16384x32_m32_be_wrap u_sram (
      .clk  (clk),
      .cen  (~(any_gnt && bank == BSEL_W'(i))),
      .gwen (~prog_gnt_o),
      .ben  (prog_gnt_o ? ~prog_be_i : 4'hF),
      .a    (addr[15:2]),
      .d    (prog_wdata_i),
      .q    (q[i])
    );
  end
  assign rd_mux = q[bank_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      bank_q   <= '0;
    end else begin
      rvalid_q <= instr_gnt_o;
      if (instr_gnt_o) bank_q <= bank;
    end
`ifdef ICCM_RDATA_REG_EN
  logic        rvalid_r;
  logic [31:0] rdata_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else begin
      rvalid_r <= rvalid_q;
      if (rvalid_q) rdata_r <= rd_mux;
    end
  assign instr_rvalid_o = rvalid_r;
  assign instr_rdata_o  = rdata_r;
`else
  logic [31:0] hold_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold_q <= '0;
    else if (rvalid_q) hold_q <= rd_mux;
  assign instr_rvalid_o = rvalid_q;
  assign instr_rdata_o  = rvalid_q ? rd_mux : hold_q;
`endif
endmodule

// File: tb/tb_iccm_banked_sram_ctrl.sv
// tb_iccm_banked_sram_ctrl: table-driven bench with fetch scoreboard; second instance covers 4 banks / absolute program priority.
module tb_iccm_banked_sram_ctrl;
`ifdef ICCM_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct {
    logic        preq;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic [3:0]  be;
    logic        ireq;
    logic [31:0] iaddr;
    logic        epg;
    logic        eig;
    logic [31:0] edata;
  } vec_t;
  typedef struct {
    logic [31:0] d;
    int          c;
  } sb_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic preq = 0, ireq = 0, pg, ig, rv;
  logic [31:0] paddr = 0, pdata = 0, iaddr = 0, rd;
  logic [3:0] pbe = 0;
  logic b_preq = 0, b_ireq = 0, b_pg, b_ig, b_rv;
  logic [31:0] b_paddr = 0, b_pdata = 0, b_iaddr = 0, b_rd;
  logic [3:0] b_pbe = 0;
  int tests = 0, fails = 0, cyc = 0;
  sb_t sb[$];
  logic [31:0] last = 0;
  vec_t vt[19];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iccm_banked_sram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(ig),
    .instr_rvalid_o(rv), .instr_rdata_o(rd),
    .prog_req_i(preq), .prog_addr_i(paddr), .prog_wdata_i(pdata),
    .prog_be_i(pbe), .prog_gnt_o(pg)
  );

  iccm_banked_sram_ctrl #(.NUM_BANKS(4), .MAX_PROG_BURST(0)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(b_ireq), .instr_addr_i(b_iaddr), .instr_gnt_o(b_ig),
    .instr_rvalid_o(b_rv), .instr_rdata_o(b_rd),
    .prog_req_i(b_preq), .prog_addr_i(b_paddr), .prog_wdata_i(b_pdata),
    .prog_be_i(b_pbe), .prog_gnt_o(b_pg)
  );

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction

  // scoreboard consumer: every rvalid must match the oldest expectation, LAT cycles after its grant
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rvalid", {31'b0, rv}, 0);
      chk("rst_rdata", rd, 0);
      sb.delete();
      last = 0;
    end else begin
      chk("gnt_excl", {31'b0, pg & ig}, 0);
      chk("pgnt_noreq", {31'b0, pg & ~preq}, 0);
      chk("igrant_noreq", {31'b0, ig & ~ireq}, 0);
      if (rv) begin
        if (sb.size() == 0) chk("rvalid_unexpected", 1, 0);
        else begin
          sb_t e;
          e = sb.pop_front();
          chk("rdata", rd, e.d);
          chk("latency", cyc - e.c, LAT);
        end
        last = rd;
      end else chk("rdata_hold", rd, last);
    end
  end

  task automatic drive(vec_t v);
    @(posedge clk);
    #1;
    preq = v.preq; paddr = v.paddr; pdata = v.pdata; pbe = v.be;
    ireq = v.ireq; iaddr = v.iaddr;
    if (v.eig) sb.push_back('{d: v.edata, c: cyc});
    @(negedge clk);
    chk("prog_gnt", {31'b0, pg}, {31'b0, v.epg});
    chk("instr_gnt", {31'b0, ig}, {31'b0, v.eig});
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive('{0, 0, 0, 0, 0, 0, 0, 0, 0});
  endtask

  initial begin
    logic [31:0] bexp [2];
    int n;
    vt[0]  = '{1, 32'h0000_0004, 32'h0BAD0001, 4'hF, 0, 0, 1, 0, 0};
    vt[1]  = '{1, 32'h0001_0004, 32'hDEADBEEF, 4'hF, 0, 0, 1, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 1, 32'h0001_0004, 0, 1, 32'hDEADBEEF};
    vt[3]  = '{0, 0, 0, 0, 1, 32'h0000_0004, 0, 1, 32'h0BAD0001};
    vt[4]  = '{1, 32'h0000_0000, 32'h11223344, 4'hF, 0, 0, 1, 0, 0};
    vt[5]  = '{1, 32'h0000_0000, 32'hAABBCCDD, 4'h5, 0, 0, 1, 0, 0};
    vt[6]  = '{0, 0, 0, 0, 1, 32'h0000_0000, 0, 1, 32'h11BB33DD};
    vt[7]  = '{1, 32'h0001_0000, 32'h55667788, 4'hF, 0, 0, 1, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 1, 32'h0000_0000, 0, 1, 32'h11BB33DD};
    vt[9]  = '{0, 0, 0, 0, 1, 32'h0001_0000, 0, 1, 32'h55667788};
    vt[10] = '{0, 0, 0, 0, 1, 32'h0000_0000, 0, 1, 32'h11BB33DD};
    vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[12] = '{1, 32'h0000_0000, 32'hFFFFFFFF, 4'hF, 0, 0, 1, 0, 0};
    vt[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[14] = '{1, 32'h0000_0000, 32'h00000000, 4'h0, 0, 0, 1, 0, 0};
    vt[15] = '{0, 0, 0, 0, 1, 32'h0000_0000, 0, 1, 32'hFFFFFFFF};
    vt[16] = '{1, 32'h0000_0008, 32'h00000077, 4'hF, 1, 32'h0000_0004, 1, 0, 0};
    vt[17] = '{0, 0, 0, 0, 1, 32'h0002_0004, 0, 1, 32'h0BAD0001};
    vt[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 19; i++) drive(vt[i]);
    idle(3);
    // both requesters held: 8 program grants then one fetch, repeating
    for (int k = 0; k < 27; k++)
      drive('{1, 32'h0001_0008, k, 4'hF, 1, 32'h0000_0004, (k % 9) != 8, (k % 9) == 8, 32'h0BAD0001});
    idle(4);
    // reset right after a fetch grant drops the pending rvalid
    drive('{0, 0, 0, 0, 1, 32'h0001_0000, 0, 1, 32'h55667788});
    #2;
    rst_n = 1'b0;
    ireq = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    drive('{0, 0, 0, 0, 1, 32'h0001_0004, 0, 1, 32'hDEADBEEF});
    idle(4);
    chk("sb_drain", sb.size(), 0);
    // four-bank instance: bank 3 word 2, then its alias
    bexp[0] = 32'hCAFE0003;
    bexp[1] = 32'hCAFE0003;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      b_preq = k < 2;
      b_paddr = k == 0 ? 32'h0003_0008 : 32'h0002_0008;
      b_pdata = k == 0 ? 32'hCAFE0003 : 32'h22220002;
      b_pbe = 4'hF;
      b_ireq = k == 2 || k == 3;
      b_iaddr = k == 2 ? 32'h0003_0008 : 32'h0007_0008;
      @(negedge clk);
      chk("b_prog_gnt", {31'b0, b_pg}, {31'b0, k < 2});
      chk("b_instr_gnt", {31'b0, b_ig}, {31'b0, k == 2 || k == 3});
      if (b_rv) begin
        if (n < 2) chk("b_rdata", b_rd, bexp[n]);
        n++;
      end
    end
    chk("b_rvalid_count", n, 2);
    // program has absolute priority when the burst budget is zero
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      b_preq = 1; b_ireq = 1; b_paddr = 32'h0000_0100; b_pdata = k; b_iaddr = 0;
      @(negedge clk);
      chk("b_starve_igrant", {31'b0, b_ig}, 0);
      chk("b_starve_pgnt", {31'b0, b_pg}, 1);
    end
    @(posedge clk);
    #1 b_preq = 0; b_ireq = 0;
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
